// File: rtl/bsg_cache_pkg.sv
// Shared cache types and width helpers: flush FSM states and store-buffer
// entry / address-field geometry used by the store-buffer drain stage.
package bsg_cache_pkg;

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_DRAIN = 2'd1,
    FLUSH_DONE  = 2'd2
  } flush_state_e;

  // A single way still needs a one-bit way_id field in the entry.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Entry layout, MSB to LSB: {way_id, addr, data, mask}.
  function automatic int sbuf_entry_width(input int addr_w, input int data_w, input int ways);
    return safe_clog2(ways) + addr_w + data_w + data_w / 8;
  endfunction

  // Byte offset bits dropped from the address: {tag, index, word, byte}.
  function automatic int byte_offset_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int dma_addr_width(input int sets, input int block_words);
    return $clog2(sets) + $clog2(block_words);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that saturates at max_val_p.
module bsg_counter_clear_up #(
  parameter int max_val_p = 8,
  localparam int width_lp = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] count_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (up_i && (count_r != width_lp'(max_val_p))) begin
      count_r <= count_r + 1'b1;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bsg_cache_sbuf_drain.sv
// Drains the store-buffer head into the data memory through a single stage
// register, with starvation priority escalation and a drain-all flush FSM.
module bsg_cache_sbuf_drain
  import bsg_cache_pkg::*;
#(
  parameter int data_width_p          = 32,
  parameter int addr_width_p          = 32,
  parameter int ways_p                = 2,
  parameter int sets_p                = 8,
  parameter int block_size_in_words_p = 4,
  parameter int starve_limit_p        = 8,
  localparam int mask_w  = data_width_p / 8,
  localparam int dma_w   = dma_addr_width(sets_p, block_size_in_words_p),
  localparam int entry_w = sbuf_entry_width(addr_width_p, data_width_p, ways_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [entry_w-1:0]               sbuf_entry_i,
  input  logic                             sbuf_v_i,
  output logic                             sbuf_yumi_o,
  output logic                             data_mem_v_o,
  output logic                             data_mem_w_o,
  output logic [dma_w-1:0]                 data_mem_addr_o,
  output logic [data_width_p*ways_p-1:0]   data_mem_data_o,
  output logic [mask_w*ways_p-1:0]         data_mem_w_mask_o,
  input  logic                             data_mem_busy_i,
  output logic                             priority_o,
  input  logic                             flush_v_i,
  output logic                             flush_done_o,
  output logic                             idle_o
);

  localparam int way_w  = safe_clog2(ways_p);
  localparam int byte_w = byte_offset_width(data_width_p);
  localparam int cnt_w  = $clog2(starve_limit_p + 1);

  logic               stage_v_r;
  logic [entry_w-1:0] entry_r;
  logic               write_fire;

  logic [mask_w-1:0]       entry_mask;
  logic [data_width_p-1:0] entry_data;
  logic [addr_width_p-1:0] entry_addr;
  logic [way_w-1:0]        entry_way;
  logic                    unused_addr_bits;

  flush_state_e      state_r;
  logic              flush_armed_r;
  logic              flush_done_r;
  logic [cnt_w-1:0]  starve_cnt;

  assign write_fire  = stage_v_r & ~data_mem_busy_i;
  // Gated by reset so nothing is consumed from the buffer while in reset.
  assign sbuf_yumi_o = reset_n_i & sbuf_v_i & (~stage_v_r | write_fire);

  // Stage register: control is reset, the held entry is not.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stage_v_r <= 1'b0;
    end else if (sbuf_yumi_o) begin
      stage_v_r <= 1'b1;
    end else if (write_fire) begin
      stage_v_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sbuf_yumi_o) begin
      entry_r <= sbuf_entry_i;
    end
  end

  assign entry_mask = entry_r[mask_w-1:0];
  assign entry_data = entry_r[mask_w +: data_width_p];
  assign entry_addr = entry_r[mask_w+data_width_p +: addr_width_p];
  assign entry_way  = entry_r[entry_w-1 -: way_w];
  // Tag and byte-offset bits do not address the data array.
  assign unused_addr_bits = ^entry_addr;

  assign data_mem_v_o    = stage_v_r;
  assign data_mem_w_o    = stage_v_r;
  assign data_mem_addr_o = entry_addr[byte_w +: dma_w];
  assign data_mem_data_o = {ways_p{entry_data}};

  always_comb begin
    data_mem_w_mask_o = '0;
    for (int w = 0; w < ways_p; w++) begin
      if (entry_way == way_w'(w)) begin
        data_mem_w_mask_o[w*mask_w +: mask_w] = entry_mask;
      end
    end
  end

  bsg_counter_clear_up #(
    .max_val_p(starve_limit_p)
  ) starve_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (write_fire),
    .up_i     (stage_v_r & data_mem_busy_i),
    .count_o  (starve_cnt)
  );

  assign priority_o = (starve_cnt == cnt_w'(starve_limit_p))
                    | ((state_r == FLUSH_DRAIN) & stage_v_r);

  // A held flush level must drop for a cycle before it can start another drain.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r       <= FLUSH_IDLE;
      flush_armed_r <= 1'b1;
      flush_done_r  <= 1'b0;
    end else begin
      flush_done_r <= 1'b0;
      if (!flush_v_i) begin
        flush_armed_r <= 1'b1;
      end
      case (state_r)
        FLUSH_IDLE: begin
          if (flush_v_i && flush_armed_r) begin
            state_r       <= FLUSH_DRAIN;
            flush_armed_r <= 1'b0;
          end
        end
        FLUSH_DRAIN: begin
          if (!stage_v_r && !sbuf_v_i) begin
            state_r      <= FLUSH_DONE;
            flush_done_r <= 1'b1;
          end
        end
        FLUSH_DONE: begin
          state_r <= FLUSH_IDLE;
        end
        default: begin
          state_r <= FLUSH_IDLE;
        end
      endcase
    end
  end

  assign flush_done_o = flush_done_r;
  assign idle_o       = ~stage_v_r & ~sbuf_v_i;

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// Randomized self-checking bench for bsg_cache_sbuf_drain with an in-order
// scoreboard of accepted store-buffer entries.
module tb_bsg_cache_sbuf_drain;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int BLK  = 4;
  localparam int SL   = 8;
  localparam int EW   = 1 + AW + DW + DW / 8;
  localparam int DMA  = 5;

  typedef struct {
    logic [DMA-1:0]     addr;
    logic [DW*WAYS-1:0] data;
    logic [7:0]         mask;
    int                 cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [EW-1:0]     sbuf_entry;
  logic              sbuf_v;
  logic              sbuf_yumi;
  logic              data_mem_v;
  logic              data_mem_w;
  logic [DMA-1:0]    data_mem_addr;
  logic [DW*WAYS-1:0] data_mem_data;
  logic [7:0]        data_mem_w_mask;
  logic              busy;
  logic              prio;
  logic              flush_v;
  logic              flush_done;
  logic              idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic o_yumi, o_v, o_w, o_wr, o_prio, o_done, o_idle;
  logic [DMA-1:0]     o_addr;
  logic [DW*WAYS-1:0] o_data;
  logic [7:0]         o_mask;

  wr_t model_q[$];

  always #5 clk = ~clk;

  bsg_cache_sbuf_drain #(
    .data_width_p(DW), .addr_width_p(AW), .ways_p(WAYS), .sets_p(SETS),
    .block_size_in_words_p(BLK), .starve_limit_p(SL)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .sbuf_entry_i(sbuf_entry), .sbuf_v_i(sbuf_v),
    .sbuf_yumi_o(sbuf_yumi), .data_mem_v_o(data_mem_v), .data_mem_w_o(data_mem_w),
    .data_mem_addr_o(data_mem_addr), .data_mem_data_o(data_mem_data),
    .data_mem_w_mask_o(data_mem_w_mask), .data_mem_busy_i(busy), .priority_o(prio),
    .flush_v_i(flush_v), .flush_done_o(flush_done), .idle_o(idle)
  );

  function automatic logic [EW-1:0] make_entry(input int way, input int idx, input int word,
                                               input logic [31:0] d, input logic [3:0] m);
    logic [31:0] a;
    a = $urandom;
    a = {a[31:7], 3'(idx), 2'(word), a[1:0]};
    return {1'(way), a, d, m};
  endfunction

  function automatic logic [EW-1:0] rand_entry();
    return make_entry($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
                      $urandom, 4'($urandom));
  endfunction

  // Expected write derived from the cache address decomposition.
  function automatic wr_t expect_of(input logic [EW-1:0] e);
    wr_t r;
    logic [31:0] a;
    int way;
    a = e[67:36];
    way = int'(e[68]);
    r.addr = 5'((a / 4) % 32);
    r.data = {e[35:4], e[35:4]};
    r.mask = 8'(e[3:0]) << (4 * way);
    r.cyc = 0;
    return r;
  endfunction

  task automatic tick();
    wr_t e;
    @(negedge clk);
    o_yumi = sbuf_yumi; o_v = data_mem_v; o_w = data_mem_w; o_wr = data_mem_v & ~busy;
    o_prio = prio; o_done = flush_done; o_idle = idle;
    o_addr = data_mem_addr; o_data = data_mem_data; o_mask = data_mem_w_mask;
    if (o_yumi) begin
      e = expect_of(sbuf_entry);
      e.cyc = cyc;
      model_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sbuf_v = 1'b1; sbuf_entry = rand_entry(); busy = 1'b0; flush_v = 1'b0;
    tick(); tick();
    checks++; if (o_yumi !== 1'b0) begin errors++; $display("FAIL reset_yumi got %b want 0", o_yumi); end
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL reset_v got %b want 0", o_v); end
    checks++; if (o_prio !== 1'b0) begin errors++; $display("FAIL reset_prio got %b want 0", o_prio); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_idle !== 1'b0) begin errors++; $display("FAIL reset_idle_v1 got %b want 0", o_idle); end
    sbuf_v = 1'b0;
    tick();
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle_v0 got %b want 1", o_idle); end
    model_q.delete();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wr_t e;
    sbuf_entry = make_entry(1, 3, 2, 32'hDEADBEEF, 4'hF);
    sbuf_v = 1'b1; busy = 1'b0;
    tick();
    checks++; if (o_yumi !== 1'b1 || o_v !== 1'b0) begin
      errors++; $display("FAIL single_yumi got yumi=%b v=%b want 1/0", o_yumi, o_v);
    end
    sbuf_v = 1'b0;
    tick();
    checks++; if (o_wr !== 1'b1 || o_w !== 1'b1) begin
      errors++; $display("FAIL single_write got v=%b w=%b want 1/1", o_wr, o_w);
    end
    checks++; if (o_addr !== 5'd14) begin errors++; $display("FAIL single_addr got %0d want 14", o_addr); end
    checks++; if (o_data !== 64'hDEADBEEF_DEADBEEF) begin
      errors++; $display("FAIL single_data got %h want deadbeefdeadbeef", o_data);
    end
    checks++; if (o_mask !== 8'hF0) begin errors++; $display("FAIL single_mask got %h want f0", o_mask); end
    if (model_q.size() != 0) e = model_q.pop_front();
    tick();
    checks++; if (o_v !== 1'b0 || o_idle !== 1'b1) begin
      errors++; $display("FAIL single_after got v=%b idle=%b want 0/1", o_v, o_idle);
    end
  endtask

  task automatic test_stream(input int n, input int busy_pct, input string name);
    int sent = 0;
    int got = 0;
    int budget = 0;
    logic sv_was;
    wr_t e;
    model_q.delete();
    sbuf_v = 1'b1; sbuf_entry = rand_entry();
    busy = ($urandom_range(0, 99) < busy_pct);
    while ((sent < n || got < sent) && budget < 500) begin
      sv_was = sbuf_v;
      tick();
      budget++;
      if (o_yumi) sent++;
      checks++; if (o_w !== o_v) begin errors++; $display("FAIL %s_wen got %b want %b", name, o_w, o_v); end
      if (o_v && busy && o_yumi) begin
        checks++; errors++; $display("FAIL %s_overwrite got yumi=1 want 0 while stalled", name);
      end
      if (busy_pct == 0 && sv_was) begin
        checks++; if (o_yumi !== 1'b1) begin errors++; $display("FAIL %s_throughput got yumi=%b want 1", name, o_yumi); end
      end
      if (o_wr) begin
        checks++;
        if (model_q.size() == 0) begin
          errors++; $display("FAIL %s_spurious got write addr=%0d want none", name, o_addr);
        end else begin
          e = model_q.pop_front();
          got++;
          if (o_addr !== e.addr || o_data !== e.data || o_mask !== e.mask) begin
            errors++;
            $display("FAIL %s_write got %0d/%h/%h want %0d/%h/%h", name, o_addr, o_data, o_mask,
                     e.addr, e.data, e.mask);
          end
          if (busy_pct == 0 && (cyc - 1 - e.cyc) != 1) begin
            errors++; $display("FAIL %s_latency got %0d want 1", name, cyc - 1 - e.cyc);
          end
        end
      end
      if (o_yumi) sbuf_entry = rand_entry();
      if (sent >= n) sbuf_v = 1'b0;
      busy = ($urandom_range(0, 99) < busy_pct);
    end
    busy = 1'b0; sbuf_v = 1'b0;
    checks++; if (sent != n || got != n) begin
      errors++; $display("FAIL %s_count got sent=%0d wrote=%0d want %0d", name, sent, got, n);
    end
  endtask

  task automatic test_starve();
    int blocked = 0;
    wr_t e;
    model_q.delete();
    sbuf_entry = rand_entry(); sbuf_v = 1'b1; busy = 1'b1;
    tick();
    sbuf_entry = rand_entry();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (o_prio !== (blocked >= SL)) begin
        errors++; $display("FAIL starve_prio_%0d got %b want %b", k, o_prio, blocked >= SL);
      end
      checks++; if (o_yumi !== 1'b0) begin errors++; $display("FAIL starve_yumi_%0d got 1 want 0", k); end
      blocked++;
    end
    busy = 1'b0;
    tick();
    checks++; if (o_wr !== 1'b1 || o_prio !== 1'b1) begin
      errors++; $display("FAIL starve_release got wr=%b prio=%b want 1/1", o_wr, o_prio);
    end
    e = model_q.pop_front();
    checks++; if (o_data !== e.data || o_addr !== e.addr) begin
      errors++; $display("FAIL starve_data got %h want %h", o_data, e.data);
    end
    sbuf_v = 1'b0;
    tick();
    checks++; if (o_prio !== 1'b0 || o_wr !== 1'b1) begin
      errors++; $display("FAIL starve_drop got prio=%b wr=%b want 0/1", o_prio, o_wr);
    end
    if (model_q.size() != 0) e = model_q.pop_front();
    tick();
  endtask

  task automatic test_flush();
    int sent = 0;
    int writes = 0;
    int dones = 0;
    wr_t e;
    model_q.delete();
    sbuf_entry = rand_entry(); sbuf_v = 1'b1; busy = 1'b0; flush_v = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      checks++; if (o_prio !== o_v) begin errors++; $display("FAIL flush_prio_%0d got %b want %b", k, o_prio, o_v); end
      if (o_wr) begin
        e = model_q.pop_front();
        writes++;
        checks++; if (o_data !== e.data || o_mask !== e.mask) begin
          errors++; $display("FAIL flush_write got %h want %h", o_data, e.data);
        end
      end
      if (o_done) begin
        dones++;
        checks++; if (writes != 3) begin errors++; $display("FAIL flush_early got writes=%0d want 3", writes); end
      end
      if (o_yumi) begin sent++; sbuf_entry = rand_entry(); end
      if (sent >= 3) sbuf_v = 1'b0;
    end
    checks++; if (dones != 1 || writes != 3) begin
      errors++; $display("FAIL flush_summary got dones=%0d writes=%0d want 1/3", dones, writes);
    end
    flush_v = 1'b0;
    tick();
  endtask

  task automatic test_flush_empty();
    logic [6:0] seq;
    logic [3:0] seq2;
    flush_v = 1'b1; sbuf_v = 1'b0; busy = 1'b0;
    for (int k = 0; k < 7; k++) begin tick(); seq[k] = o_done; end
    checks++; if (seq !== 7'b0000100) begin errors++; $display("FAIL flush_empty_seq got %b want 0000100", seq); end
    flush_v = 1'b0; tick();
    flush_v = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); seq2[k] = o_done; end
    checks++; if (seq2 !== 4'b0100) begin errors++; $display("FAIL flush_retrigger got %b want 0100", seq2); end
    flush_v = 1'b0; tick();
  endtask

  task automatic test_reset_mid_write();
    wr_t e;
    int dones = 0;
    model_q.delete();
    sbuf_entry = rand_entry(); sbuf_v = 1'b1; busy = 1'b1; flush_v = 1'b1;
    tick();
    sbuf_v = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL rstmid_write got %b want 0", o_wr); end
    busy = 1'b0; flush_v = 1'b0;
    tick();
    model_q.delete();
    checks++; if (o_v !== 1'b0 || o_yumi !== 1'b0 || o_prio !== 1'b0 || o_done !== 1'b0 || o_idle !== 1'b1) begin
      errors++; $display("FAIL rstmid_outputs got v=%b yumi=%b prio=%b done=%b idle=%b want 0/0/0/0/1",
                         o_v, o_yumi, o_prio, o_done, o_idle);
    end
    reset_n = 1'b1;
    sbuf_entry = rand_entry(); sbuf_v = 1'b1;
    tick();
    checks++; if (o_yumi !== 1'b1 || o_v !== 1'b0) begin
      errors++; $display("FAIL rstmid_fresh_yumi got yumi=%b v=%b want 1/0", o_yumi, o_v);
    end
    if (o_done) dones++;
    sbuf_v = 1'b0;
    tick();
    if (o_done) dones++;
    e = model_q.pop_front();
    checks++; if (o_wr !== 1'b1 || o_addr !== e.addr || o_data !== e.data || o_mask !== e.mask) begin
      errors++; $display("FAIL rstmid_fresh_write got wr=%b %0d/%h want 1 %0d/%h", o_wr, o_addr, o_data, e.addr, e.data);
    end
    for (int k = 0; k < 3; k++) begin tick(); if (o_done) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_flush_done got %0d want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream(20, 0, "b2b");
    test_stream(40, 40, "rand");
    test_starve();
    test_flush();
    test_flush_empty();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
